// File: rtl/sdram_arb_pkg.sv
// Shared types for the SDRAM tape arbiter: FSM states, requester ids, in-flight command record.
package sdram_arb_pkg;
  typedef enum logic [2:0] {IDLE, ISSUE, LAG, WAIT, DONE} arb_state_t;
  typedef enum logic [1:0] {P_DL, P_CAS, P_CLI} port_id_t;

  localparam logic [7:0] READ_ABORT_DATA = 8'hFF;

  typedef struct packed {
    port_id_t port;
    logic     we;
    logic     abort;
  } cmd_t;
endpackage

// File: rtl/sdram_tape_arbiter_rr_pick2.sv
// Two-request round-robin picker; the pointer moves only when the caller commits a grant.
module rr_pick2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic [1:0] gnt
);
  logic prio_hi;  // 0: req[0] preferred, 1: req[1] preferred

  always_comb begin
    gnt = 2'b00;
    if (req[0] && (!prio_hi || !req[1])) gnt[0] = 1'b1;
    else if (req[1])                     gnt[1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                prio_hi <= 1'b0;
    else if (update && |gnt)   prio_hi <= gnt[0];
  end
endmodule

// File: rtl/sdram_tape_arbiter.sv
// Arbitrates the byte-wide SDRAM port between download (port 0), cassette (1) and client (2).
// Define SDRAM_ARB_STATS_EN to add per-port grant counters and a max WAIT-length monitor.
module sdram_tape_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int ADDR_W      = 25,
  parameter int READY_LAG   = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              CLK50MHZ,
  input  logic              COCO_RESET_N,
  input  logic              dl_wr,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [7:0]        dl_data,
  output logic              dl_overrun,
  input  logic              p1_req,
  input  logic [ADDR_W-1:0] p1_addr,
  output logic              p1_ack,
  output logic [7:0]        p1_rdata,
  input  logic              p2_req,
  input  logic              p2_we,
  input  logic [ADDR_W-1:0] p2_addr,
  input  logic [7:0]        p2_wdata,
  output logic              p2_ack,
  output logic [7:0]        p2_rdata,
  output logic [ADDR_W-1:0] sdram_addr,
  output logic [7:0]        sdram_din,
  output logic              sdram_rd,
  output logic              sdram_we,
  input  logic [7:0]        sdram_dout,
  input  logic              sdram_ready,
  output logic              timeout_err
`ifdef SDRAM_ARB_STATS_EN
  ,
  output logic [15:0]       stat_grants0,
  output logic [15:0]       stat_grants1,
  output logic [15:0]       stat_grants2,
  output logic [7:0]        stat_max_wait
`endif
);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int LW = (READY_LAG > 1) ? $clog2(READY_LAG) : 1;

  arb_state_t        state, state_nx;
  cmd_t              cmd;
  logic              dl_pend;
  logic [ADDR_W-1:0] dl_a;
  logic [7:0]        dl_d;
  logic [LW-1:0]     lag_cnt;
  logic [TW-1:0]     tcnt;
  logic [7:0]        p1_q, p2_q, rd_val;
  logic [1:0]        rr_gnt;
  logic              dl_go, dl_free, is_done, grant_go, rr_upd, to_abort;

  rr_pick2 u_rr (
    .clk    (CLK50MHZ),
    .rst_n  (COCO_RESET_N),
    .req    ({p2_req, p1_req}),
    .update (rr_upd),
    .gnt    (rr_gnt)
  );

  // A strobe arriving in an idle cycle competes as if already held, so it is never overtaken.
  assign dl_go   = dl_pend | dl_wr;
  assign is_done = (state == DONE);
  assign dl_free = is_done && (cmd.port == P_DL);

  always_comb begin
    state_nx = state;
    grant_go = 1'b0;
    rr_upd   = 1'b0;
    to_abort = 1'b0;
    case (state)
      IDLE:  if (sdram_ready && (dl_go || |rr_gnt)) begin
               state_nx = ISSUE;
               grant_go = 1'b1;
               rr_upd   = !dl_go;
             end
      ISSUE: state_nx = (READY_LAG == 0) ? WAIT : LAG;
      LAG:   if (lag_cnt == LW'(READY_LAG - 1)) state_nx = WAIT;
      WAIT:  if (sdram_ready) state_nx = DONE;
             else if (tcnt == TW'(TIMEOUT_CYC)) begin
               state_nx = DONE;
               to_abort = 1'b1;
             end
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sdram_rd = (state == ISSUE) && !cmd.we;
  assign sdram_we = (state == ISSUE) &&  cmd.we;
  assign rd_val   = cmd.abort ? READ_ABORT_DATA : sdram_dout;
  assign p1_ack   = is_done && (cmd.port == P_CAS);
  assign p2_ack   = is_done && (cmd.port == P_CLI);
  // Read data is live during the ack cycle and held from the capture register afterwards.
  assign p1_rdata = (p1_ack && !cmd.we) ? rd_val : p1_q;
  assign p2_rdata = (p2_ack && !cmd.we) ? rd_val : p2_q;

  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      state       <= IDLE;
      cmd         <= '{port: P_DL, we: 1'b0, abort: 1'b0};
      dl_pend     <= 1'b0;
      dl_a        <= '0;
      dl_d        <= '0;
      dl_overrun  <= 1'b0;
      sdram_addr  <= '0;
      sdram_din   <= '0;
      lag_cnt     <= '0;
      tcnt        <= '0;
      timeout_err <= 1'b0;
      p1_q        <= '0;
      p2_q        <= '0;
    end else begin
      state <= state_nx;

      if (dl_wr) begin
        if (dl_pend && !dl_free) dl_overrun <= 1'b1;
        else begin
          dl_pend <= 1'b1;
          dl_a    <= dl_addr;
          dl_d    <= dl_data;
        end
      end else if (dl_free) begin
        dl_pend <= 1'b0;
      end

      if (grant_go) begin
        cmd.abort <= 1'b0;
        if (dl_go) begin
          cmd.port   <= P_DL;
          cmd.we     <= 1'b1;
          sdram_addr <= dl_pend ? dl_a : dl_addr;
          sdram_din  <= dl_pend ? dl_d : dl_data;
        end else if (rr_gnt[0]) begin
          cmd.port   <= P_CAS;
          cmd.we     <= 1'b0;
          sdram_addr <= p1_addr;
        end else begin
          cmd.port   <= P_CLI;
          cmd.we     <= p2_we;
          sdram_addr <= p2_addr;
          sdram_din  <= p2_wdata;
        end
      end

      if (to_abort) begin
        cmd.abort   <= 1'b1;
        timeout_err <= 1'b1;
      end

      lag_cnt <= (state == LAG)  ? lag_cnt + 1'b1 : '0;
      tcnt    <= (state == WAIT) ? tcnt + 1'b1    : '0;

      if (p1_ack && !cmd.we) p1_q <= rd_val;
      if (p2_ack && !cmd.we) p2_q <= rd_val;
    end
  end

`ifdef SDRAM_ARB_STATS_EN
  logic [7:0] wait_len;

  always_comb begin
    wait_len = 8'hFF;
    if (int'(tcnt) < 255) wait_len = 8'(int'(tcnt) + 1);
  end

  always_ff @(posedge CLK50MHZ or negedge COCO_RESET_N) begin
    if (!COCO_RESET_N) begin
      stat_grants0  <= '0;
      stat_grants1  <= '0;
      stat_grants2  <= '0;
      stat_max_wait <= '0;
    end else begin
      if (is_done) begin
        case (cmd.port)
          P_DL:  if (stat_grants0 != 16'hFFFF) stat_grants0 <= stat_grants0 + 1'b1;
          P_CAS: if (stat_grants1 != 16'hFFFF) stat_grants1 <= stat_grants1 + 1'b1;
          P_CLI: if (stat_grants2 != 16'hFFFF) stat_grants2 <= stat_grants2 + 1'b1;
          default: ;
        endcase
      end
      if (state == WAIT && state_nx == DONE && wait_len > stat_max_wait)
        stat_max_wait <= wait_len;
    end
  end
`endif
endmodule

// File: tb/tb_sdram_tape_arbiter.sv
// Directed + randomized bench: behavioural SDRAM controller, byte memory model and
// round-robin service-order model checked against the arbiter's acks and commands.
module tb_sdram_tape_arbiter;
  localparam int ADDR_W      = 25;
  localparam int TIMEOUT_CYC = 255;

  logic              CLK50MHZ = 1'b0;
  logic              COCO_RESET_N = 1'b0;
  logic              dl_wr = 1'b0;
  logic [ADDR_W-1:0] dl_addr = '0;
  logic [7:0]        dl_data = '0;
  logic              dl_overrun;
  logic              p1_req = 1'b0;
  logic [ADDR_W-1:0] p1_addr = '0;
  logic              p1_ack;
  logic [7:0]        p1_rdata;
  logic              p2_req = 1'b0, p2_we = 1'b0;
  logic [ADDR_W-1:0] p2_addr = '0;
  logic [7:0]        p2_wdata = '0;
  logic              p2_ack;
  logic [7:0]        p2_rdata;
  logic [ADDR_W-1:0] sdram_addr;
  logic [7:0]        sdram_din;
  logic              sdram_rd, sdram_we;
  logic [7:0]        sdram_dout;
  logic              sdram_ready;
  logic              timeout_err;

  sdram_tape_arbiter #(.ADDR_W(ADDR_W), .READY_LAG(2), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLK50MHZ(CLK50MHZ), .COCO_RESET_N(COCO_RESET_N),
    .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data), .dl_overrun(dl_overrun),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .p2_req(p2_req), .p2_we(p2_we), .p2_addr(p2_addr), .p2_wdata(p2_wdata),
    .p2_ack(p2_ack), .p2_rdata(p2_rdata),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din), .sdram_rd(sdram_rd), .sdram_we(sdram_we),
    .sdram_dout(sdram_dout), .sdram_ready(sdram_ready), .timeout_err(timeout_err)
  );

  always #5 CLK50MHZ = ~CLK50MHZ;

  typedef struct { logic we; logic [ADDR_W-1:0] addr; logic [7:0] din; } log_t;
  log_t       cmd_log[$];
  logic [7:0] ctl_mem [256];
  logic [7:0] ref_mem [256];
  int         tests = 0, fails = 0;
  int         lat_cfg = 1, ctl_busy = 0, last_srv = 2;
  bit         hold_low = 1'b0, ctl_rdy = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Controller model: one command at a time, ready low for lat_cfg cycles after each command.
  initial begin
    sdram_ready = 1'b1;
    sdram_dout  = 8'h00;
    forever begin
      @(negedge CLK50MHZ);
      if (ctl_busy > 0) begin
        ctl_busy--;
        if (ctl_busy == 0) ctl_rdy = 1'b1;
      end
      if (sdram_rd || sdram_we) begin
        cmd_log.push_back('{sdram_we, sdram_addr, sdram_din});
        if (sdram_we) ctl_mem[sdram_addr[7:0]] = sdram_din;
        else          sdram_dout = ctl_mem[sdram_addr[7:0]];
        ctl_rdy  = 1'b0;
        ctl_busy = lat_cfg;
      end
      sdram_ready = ctl_rdy && !hold_low;
    end
  end

  // One service round: optional download strobe plus port 1 / port 2 requests held until ack.
  task automatic serve(input bit r1, input bit r2, input bit we2,
                       input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                       input logic [7:0] wd, input bit dl,
                       input logic [ADDR_W-1:0] dla, input logic [7:0] dld,
                       input int lat, input bit abort2, output int first_n);
    int n = 0, nxt;
    bit got1 = !r1, got2 = !r2;
    int n0 = cmd_log.size();
    first_n = 0;
    lat_cfg = lat;
    @(negedge CLK50MHZ);
    p1_req = r1; p1_addr = a1;
    p2_req = r2; p2_we = we2; p2_addr = a2; p2_wdata = wd;
    dl_wr = dl; dl_addr = dla; dl_data = dld;
    if (dl) ref_mem[dla[7:0]] = dld;
    nxt = (r1 && r2) ? ((last_srv == 1) ? 2 : 1) : (r1 ? 1 : 2);
    while (!(got1 && got2) && n < 800) begin
      @(negedge CLK50MHZ);
      n++;
      dl_wr = 1'b0;
      if (p1_ack || p2_ack) begin
        if (first_n == 0) first_n = n;
        chk("single_ack", {31'd0, p1_ack && p2_ack}, 0);
        chk("ack_order", p1_ack ? 1 : 2, nxt);
        if (p1_ack) begin
          chk("p1_rdata", {24'd0, p1_rdata}, {24'd0, ref_mem[a1[7:0]]});
          chk("p1_cmd_addr", cmd_log[$].addr, a1);
          chk("p1_cmd_we", {31'd0, cmd_log[$].we}, 0);
          p1_req = 1'b0; got1 = 1'b1; last_srv = 1;
        end else begin
          chk("p2_cmd_addr", cmd_log[$].addr, a2);
          chk("p2_cmd_we", {31'd0, cmd_log[$].we}, {31'd0, we2});
          if (we2) begin
            chk("p2_cmd_din", {24'd0, cmd_log[$].din}, {24'd0, wd});
            if (!abort2) ref_mem[a2[7:0]] = wd;
          end else begin
            chk("p2_rdata", {24'd0, p2_rdata}, abort2 ? 32'hFF : {24'd0, ref_mem[a2[7:0]]});
          end
          p2_req = 1'b0; got2 = 1'b1; last_srv = 2;
        end
        nxt = 3 - last_srv;
      end
    end
    chk("acks_in_bound", {31'd0, got1 && got2}, 1);
    if (dl) begin
      chk("dl_first_we", {31'd0, cmd_log[n0].we}, 1);
      chk("dl_first_addr", cmd_log[n0].addr, dla);
      chk("dl_first_din", {24'd0, cmd_log[n0].din}, {24'd0, dld});
    end else begin
      chk("latency_min", {31'd0, first_n >= 5}, 1);
    end
  endtask

  initial begin
    int fn, n0;
    logic [ADDR_W-1:0] ra1, ra2;
    for (int i = 0; i < 256; i++) begin
      ctl_mem[i] = 8'(i * 7 + 3);
      ref_mem[i] = 8'(i * 7 + 3);
    end
    ctl_mem[0] = 8'hA5;
    ref_mem[0] = 8'hA5;

    repeat (3) @(negedge CLK50MHZ);
    chk("rst_rd", {31'd0, sdram_rd}, 0);
    chk("rst_we", {31'd0, sdram_we}, 0);
    chk("rst_addr", sdram_addr, 0);
    chk("rst_acks", {30'd0, p1_ack, p2_ack}, 0);
    chk("rst_flags", {30'd0, dl_overrun, timeout_err}, 0);
    COCO_RESET_N = 1'b1;
    repeat (2) @(negedge CLK50MHZ);

    // Single read with controller busy for 3 cycles.
    n0 = cmd_log.size();
    serve(1, 0, 0, 25'h000100, '0, 8'h00, 0, '0, 8'h00, 3, 0, fn);
    chk("t1_one_cmd", cmd_log.size() - n0, 1);
    chk("t1_rdata", {24'd0, p1_rdata}, 32'hA5);

    // Download strobe in the same cycle as both requests.
    serve(1, 1, 0, 25'h000033, 25'h000044, 8'h00, 1, 25'h10, 8'h3C, 1, 0, fn);

    // Overrun while the controller is held busy.
    hold_low = 1'b1;
    repeat (2) @(negedge CLK50MHZ);
    n0 = cmd_log.size();
    chk("ovr_clear", {31'd0, dl_overrun}, 0);
    dl_wr = 1'b1; dl_addr = 25'h50; dl_data = 8'h11;
    @(negedge CLK50MHZ);
    dl_data = 8'h22;
    @(negedge CLK50MHZ);
    dl_wr = 1'b0;
    chk("ovr_set", {31'd0, dl_overrun}, 1);
    hold_low = 1'b0;
    repeat (40) @(negedge CLK50MHZ);
    chk("ovr_cmd_cnt", cmd_log.size() - n0, 1);
    chk("ovr_din", {24'd0, cmd_log[n0].din}, 32'h11);
    chk("ovr_addr", cmd_log[n0].addr, 25'h50);
    ref_mem[8'h50] = 8'h11;
    serve(1, 0, 0, 25'h50, '0, 8'h00, 0, '0, 8'h00, 2, 0, fn);
    chk("ovr_sticky", {31'd0, dl_overrun}, 1);

    // Fairness: both requesters for three rounds (six transactions).
    for (int k = 0; k < 3; k++)
      serve(1, 1, 1, ADDR_W'(k + 8'h60), ADDR_W'(k + 8'h70), 8'(8'h90 + k), 0, '0, 8'h00, 1, 0, fn);

    // Timeout: controller stays busy far longer than the abort limit.
    chk("to_clear", {31'd0, timeout_err}, 0);
    serve(0, 1, 0, '0, 25'h40, 8'h00, 0, '0, 8'h00, 400, 1, fn);
    chk("to_latency", {31'd0, fn >= TIMEOUT_CYC}, 1);
    chk("to_err", {31'd0, timeout_err}, 1);
    serve(1, 0, 0, 25'h41, '0, 8'h00, 0, '0, 8'h00, 1, 0, fn);

    // Reset in the middle of WAIT.
    lat_cfg = 30;
    @(negedge CLK50MHZ);
    p1_req = 1'b1; p1_addr = 25'h22;
    repeat (6) @(negedge CLK50MHZ);
    COCO_RESET_N = 1'b0;
    #1;
    chk("mid_rst_ack", {30'd0, p1_ack, p2_ack}, 0);
    chk("mid_rst_cmd", {30'd0, sdram_rd, sdram_we}, 0);
    chk("mid_rst_addr", sdram_addr, 0);
    chk("mid_rst_rdata", {16'd0, p1_rdata, p2_rdata}, 0);
    chk("mid_rst_flags", {30'd0, dl_overrun, timeout_err}, 0);
    p1_req = 1'b0;
    last_srv = 2;
    n0 = cmd_log.size();
    repeat (3) @(negedge CLK50MHZ);
    COCO_RESET_N = 1'b1;
    fn = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge CLK50MHZ);
      if (p1_ack || p2_ack) fn++;
    end
    chk("post_rst_quiet", {31'd0, fn == 0 && cmd_log.size() == n0}, 1);
    serve(1, 0, 0, 25'h22, '0, 8'h00, 0, '0, 8'h00, 2, 0, fn);

    // Randomized rounds against the memory and service-order model.
    for (int k = 0; k < 24; k++) begin
      bit r1, r2, dl;
      r1 = 1'($urandom_range(0, 1));
      r2 = r1 ? 1'($urandom_range(0, 1)) : 1'b1;
      dl = ($urandom_range(0, 3) == 0);
      ra1 = ADDR_W'($urandom);
      ra2 = ADDR_W'($urandom);
      serve(r1, r2, 1'($urandom_range(0, 1)), ra1, ra2, 8'($urandom), dl,
            ADDR_W'($urandom), 8'($urandom), $urandom_range(1, 5), 0, fn);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
